// File: rtl/ethmac_lite_tx_if.sv
// ethmac_lite_tx_if: 32-bit Wishbone bus bundle for the ethmac_lite_tx
// transmit core.
//
// Signals (as seen from the slave side):
//   wb_adr_i  [7:0]  byte address, bits [1:0] ignored
//   wb_dat_i  [31:0] write data
//   wb_dat_o  [31:0] read data, valid while wb_ack_o=1, 0 otherwise
//   wb_we_i          1=write, 0=read
//   wb_sel_i  [3:0]  byte selects, ignored (all accesses are full-word)
//   wb_stb_i         strobe
//   wb_cyc_i         cycle
//   wb_ack_o         transfer acknowledge
//   wb_err_o         error acknowledge for unmapped addresses
//
// Modports: slave (the MAC core), master (host / bus fabric).
interface ethmac_lite_tx_if;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/ethmac_lite_tx.sv
// ethmac_lite_tx: single-clock Ethernet MAC transmit core.
// Host loads a frame into the word buffer over Wishbone, programs LEN and
// sets START; the core sends preamble, SFD and data as one nibble per clk.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous, active-low reset
//   wb       Wishbone slave (ethmac_lite_tx_if.slave)
//   int_o    interrupt = |(INT_SRC & INT_MASK)
//   mtxd_o   transmit nibble (0 whenever mtxen_o=0)
//   mtxen_o  transmit enable
//
// Parameters: TX_DEPTH (buffer words, at most 48), PREAMBLE_NIB (0x5 count).
// Optional feature: define ETHMAC_CRC_EN to make MODER.CRCEN writable and
// append a CRC-32 FCS after the data; without it no FCS logic exists.
module ethmac_lite_tx #(
    parameter int TX_DEPTH     = 16,
    parameter int PREAMBLE_NIB = 15
) (
    input  logic               clk,
    input  logic               rst,
    ethmac_lite_tx_if.slave    wb,
    output logic               int_o,
    output logic [3:0]         mtxd_o,
    output logic               mtxen_o
);
    localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS} state_t;

    state_t      state_reg;
    logic [16:0] cnt_reg;
    logic [15:0] flen_reg;
    logic [31:0] data_sr_reg;
    logic        mtxen_reg;
    logic [3:0]  mtxd_reg;
    logic        txen_reg;
    logic [1:0]  int_src_reg;
    logic [1:0]  int_mask_reg;
    logic [15:0] len_reg;
    logic [31:0] mac0_reg;
    logic [15:0] mac1_reg;
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] reg_rd_reg;
    logic        sel_buf_reg;
    logic [31:0] buf_rd_reg;
    logic [31:0] tx_word_reg;
    logic [31:0] mem [TX_DEPTH];

    logic        crcen;
    logic        req, busy, is_reg, is_buf, valid, wr;
    logic        wr_moder, wr_int_src, wr_tx_ctrl;
    logic        start_req, len_ok, start_ok, start_bad, abort;
    logic        data_last, frame_done, buf_we;
    logic [5:0]  word_adr, buf_off;
    logic [AW-1:0] buf_idx, rd_idx;
    logic [15:0] new_len;
    logic [16:0] last_nib;
    logic [3:0]  nxt_nib;
    logic        unused_bits;

`ifdef ETHMAC_CRC_EN
    logic        crcen_reg;
    logic [31:0] crc_reg;
    assign crcen = crcen_reg;

    // Reflected CRC-32 advanced by one nibble, LSB first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`else
    assign crcen = 1'b0;
`endif

    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[1:0]};

    always_comb begin
        req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg & ~err_reg;
        word_adr   = wb.wb_adr_i[7:2];
        buf_off    = word_adr - 6'd16;
        buf_idx    = buf_off[AW-1:0];
        is_reg     = (word_adr <= 6'd5);
        is_buf     = (word_adr >= 6'd16) && (int'(buf_off) < TX_DEPTH);
        valid      = is_reg | is_buf;
        wr         = req & valid & wb.wb_we_i;
        wr_moder   = wr & (word_adr == 6'd0);
        wr_int_src = wr & (word_adr == 6'd1);
        wr_tx_ctrl = wr & (word_adr == 6'd3);
        busy       = (state_reg != IDLE);
        new_len    = wb.wb_dat_i[15:0];
        len_ok     = (new_len != 16'd0) && (int'(new_len) <= 4 * TX_DEPTH);
        start_req  = wr_tx_ctrl & wb.wb_dat_i[16] & ~busy;
        start_ok   = start_req & txen_reg & len_ok;
        start_bad  = start_req & ~start_ok;
        // Clearing TXEN aborts on the same edge the MODER write lands.
        abort      = busy & (~txen_reg | (wr_moder & ~wb.wb_dat_i[0]));
        last_nib   = {flen_reg, 1'b0} - 17'd1;
        data_last  = (state_reg == DATA) && (cnt_reg == last_nib);
        frame_done = ~abort & ((data_last & ~crcen) |
                               ((state_reg == FCS) && (cnt_reg == 17'd7)));
        buf_we     = wr & is_buf & ~busy;
        // Prefetch the next buffer word so it is ready at the word boundary.
        rd_idx     = (state_reg == DATA) ? (cnt_reg[AW+2:3] + AW'(1)) : '0;
        nxt_nib    = (cnt_reg[2:0] == 3'd7) ? tx_word_reg[3:0] : data_sr_reg[3:0];
    end

    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_err_o = err_reg;
    assign wb.wb_dat_o = ack_reg ? (sel_buf_reg ? buf_rd_reg : reg_rd_reg) : 32'd0;
    assign int_o       = |(int_src_reg & int_mask_reg);
    assign mtxd_o      = mtxd_reg;
    assign mtxen_o     = mtxen_reg;

    // Frame buffer: one write/read port for the host, one read port for TX.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[buf_idx] <= wb.wb_dat_i;
        end
        buf_rd_reg  <= mem[buf_idx];
        tx_word_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            flen_reg     <= '0;
            data_sr_reg  <= '0;
            mtxen_reg    <= 1'b0;
            mtxd_reg     <= '0;
            txen_reg     <= 1'b0;
            int_src_reg  <= '0;
            int_mask_reg <= '0;
            len_reg      <= '0;
            mac0_reg     <= '0;
            mac1_reg     <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            reg_rd_reg   <= '0;
            sel_buf_reg  <= 1'b0;
`ifdef ETHMAC_CRC_EN
            crcen_reg    <= 1'b0;
            crc_reg      <= '0;
`endif
        end else begin
            ack_reg     <= req & valid;
            err_reg     <= req & ~valid;
            sel_buf_reg <= req & is_buf & ~wb.wb_we_i;
            reg_rd_reg  <= '0;
            if (req & is_reg & ~wb.wb_we_i) begin
                case (word_adr)
                    6'd0:    reg_rd_reg <= {30'd0, crcen, txen_reg};
                    6'd1:    reg_rd_reg <= {30'd0, int_src_reg};
                    6'd2:    reg_rd_reg <= {30'd0, int_mask_reg};
                    6'd3:    reg_rd_reg <= {15'd0, busy, len_reg};
                    6'd4:    reg_rd_reg <= mac0_reg;
                    6'd5:    reg_rd_reg <= {16'd0, mac1_reg};
                    default: reg_rd_reg <= '0;
                endcase
            end

            if (wr_moder) begin
                txen_reg <= wb.wb_dat_i[0];
`ifdef ETHMAC_CRC_EN
                crcen_reg <= wb.wb_dat_i[1];
`endif
            end
            if (wr & (word_adr == 6'd2)) int_mask_reg <= wb.wb_dat_i[1:0];
            if (wr_tx_ctrl)              len_reg      <= new_len;
            if (wr & (word_adr == 6'd4)) mac0_reg     <= wb.wb_dat_i;
            if (wr & (word_adr == 6'd5)) mac1_reg     <= wb.wb_dat_i[15:0];

            // Hardware set takes priority over a write-1-to-clear.
            int_src_reg <= (int_src_reg & ~(wr_int_src ? wb.wb_dat_i[1:0] : 2'b00))
                         | {start_bad | abort, frame_done};

            if (abort) begin
                state_reg <= IDLE;
                mtxen_reg <= 1'b0;
                mtxd_reg  <= '0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_ok) begin
                            state_reg <= PRE;
                            cnt_reg   <= '0;
                            flen_reg  <= new_len;
                            mtxen_reg <= 1'b1;
                            mtxd_reg  <= 4'h5;
                        end
                    end
                    PRE: begin
                        if (cnt_reg == 17'(PREAMBLE_NIB - 1)) begin
                            state_reg <= SFD;
                            mtxd_reg  <= 4'hD;
                        end else begin
                            cnt_reg  <= cnt_reg + 17'd1;
                            mtxd_reg <= 4'h5;
                        end
                    end
                    SFD: begin
                        state_reg   <= DATA;
                        cnt_reg     <= '0;
                        mtxd_reg    <= tx_word_reg[3:0];
                        data_sr_reg <= tx_word_reg >> 4;
`ifdef ETHMAC_CRC_EN
                        crc_reg     <= crc_nib(32'hFFFFFFFF, tx_word_reg[3:0]);
`endif
                    end
                    DATA: begin
                        if (data_last) begin
`ifdef ETHMAC_CRC_EN
                            if (crcen_reg) begin
                                state_reg   <= FCS;
                                cnt_reg     <= '0;
                                mtxd_reg    <= ~crc_reg[3:0];
                                data_sr_reg <= (~crc_reg) >> 4;
                            end else begin
                                state_reg <= IDLE;
                                mtxen_reg <= 1'b0;
                                mtxd_reg  <= '0;
                            end
`else
                            state_reg <= IDLE;
                            mtxen_reg <= 1'b0;
                            mtxd_reg  <= '0;
`endif
                        end else begin
                            cnt_reg     <= cnt_reg + 17'd1;
                            mtxd_reg    <= nxt_nib;
                            data_sr_reg <= (cnt_reg[2:0] == 3'd7) ? (tx_word_reg >> 4)
                                                                  : (data_sr_reg >> 4);
`ifdef ETHMAC_CRC_EN
                            crc_reg     <= crc_nib(crc_reg, nxt_nib);
`endif
                        end
                    end
                    FCS: begin
                        if (cnt_reg == 17'd7) begin
                            state_reg <= IDLE;
                            mtxen_reg <= 1'b0;
                            mtxd_reg  <= '0;
                        end else begin
                            cnt_reg     <= cnt_reg + 17'd1;
                            mtxd_reg    <= data_sr_reg[3:0];
                            data_sr_reg <= data_sr_reg >> 4;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ethmac_lite_tx.sv
// tb_ethmac_lite_tx: self-checking bench for ethmac_lite_tx.
// Expected nibbles and frame lengths are queued when a frame is started and
// compared by a monitor as the core drives mtxd_o/mtxen_o.
module tb_ethmac_lite_tx;
    logic       clk;
    logic       rst;
    logic       int_o;
    logic [3:0] mtxd_o;
    logic       mtxen_o;

    ethmac_lite_tx_if wb_bus();

    ethmac_lite_tx #(.TX_DEPTH(16), .PREAMBLE_NIB(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .wb      (wb_bus),
        .int_o   (int_o),
        .mtxd_o  (mtxd_o),
        .mtxen_o (mtxen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [3:0]  nib_q [$];
    int          len_q [$];
    logic [31:0] buf_model [16];
    int          en_cnt       = 0;
    int          frames_seen  = 0;
    int          abort_full   = 0;
    bit          prev_en      = 1'b0;
    bit          expect_abort = 1'b0;
    logic [3:0]  mon_nib;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int k);
        logic [31:0] sh;
        sh = buf_model[k / 4] >> (8 * (k % 4));
        return sh[7:0];
    endfunction

    function automatic logic [31:0] model_fcs(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < len; k++) begin
            c = c ^ {24'd0, model_byte(k)};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_frame(input int len, input bit fcs);
        logic [7:0]  b;
        logic [31:0] c;
        for (int i = 0; i < 15; i++) nib_q.push_back(4'h5);
        nib_q.push_back(4'hD);
        for (int k = 0; k < len; k++) begin
            b = model_byte(k);
            nib_q.push_back(b[3:0]);
            nib_q.push_back(b[7:4]);
        end
        if (fcs) begin
            c = model_fcs(len);
            for (int j = 0; j < 8; j++) nib_q.push_back(c[4*j +: 4]);
        end
        len_q.push_back(16 + 2 * len + (fcs ? 8 : 0));
    endtask

    // Monitor: compare each transmitted nibble and each frame's length.
    always @(negedge clk) begin
        if (mtxen_o) begin
            en_cnt++;
            if (nib_q.size() > 0) begin
                mon_nib = nib_q.pop_front();
                check_eq("tx_nibble", {28'd0, mtxd_o}, {28'd0, mon_nib});
            end
        end else if (prev_en) begin
            check_eq("txd_idle", {28'd0, mtxd_o}, 32'd0);
            if (expect_abort) begin
                check_eq("abort_short", (en_cnt < abort_full) ? 1 : 0, 1);
                nib_q.delete();
                if (len_q.size() > 0) void'(len_q.pop_front());
                expect_abort = 1'b0;
            end else begin
                if (len_q.size() > 0) check_eq("frame_len", en_cnt, len_q.pop_front());
                else                  check_eq("unexpected_frame", en_cnt, 0);
                check_eq("nib_leftover", nib_q.size(), 0);
            end
            $display("[TB] frame %0d ended after %0d enable cycles", frames_seen, en_cnt);
            frames_seen++;
            en_cnt = 0;
        end
        prev_en = mtxen_o;
    end

    task automatic wb_xfer(input logic [7:0] adr, input bit we, input logic [31:0] dat,
                           output logic [31:0] rdat, output bit got_ack, output bit got_err);
        int n;
        @(negedge clk);
        wb_bus.wb_adr_i = adr;
        wb_bus.wb_we_i  = we;
        wb_bus.wb_dat_i = dat;
        wb_bus.wb_sel_i = 4'hF;
        wb_bus.wb_cyc_i = 1'b1;
        wb_bus.wb_stb_i = 1'b1;
        got_ack = 1'b0;
        got_err = 1'b0;
        rdat    = '0;
        n       = 0;
        while (!got_ack && !got_err && n < 4) begin
            @(negedge clk);
            n++;
            got_ack = wb_bus.wb_ack_o;
            got_err = wb_bus.wb_err_o;
            rdat    = wb_bus.wb_dat_o;
        end
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
        wb_bus.wb_we_i  = 1'b0;
        check_eq("wb_latency", n, 1);
        $display("[TB] %s adr=%02h wdat=%08h rdat=%08h ack=%0d err=%0d",
                 we ? "WR" : "RD", adr, dat, rdat, got_ack, got_err);
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        bit a, e;
        wb_xfer(adr, 1'b1, dat, r, a, e);
        check_eq("wr_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] rdat);
        bit a, e;
        wb_xfer(adr, 1'b0, 32'd0, rdat, a, e);
        check_eq("rd_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_done", frames_seen, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit a, e;
        int fs0;

        rst = 1'b0;
        wb_bus.wb_adr_i = '0;
        wb_bus.wb_dat_i = '0;
        wb_bus.wb_we_i  = 1'b0;
        wb_bus.wb_sel_i = '0;
        wb_bus.wb_stb_i = 1'b0;
        wb_bus.wb_cyc_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;

        // Reset state
        wb_read(8'h00, r); check_eq("rst_moder", r, 32'h0);
        wb_read(8'h04, r); check_eq("rst_int_src", r, 32'h0);
        wb_read(8'h0C, r); check_eq("rst_tx_ctrl", r, 32'h0);
        check_eq("rst_mtxen", {31'd0, mtxen_o}, 32'd0);
        check_eq("rst_int", {31'd0, int_o}, 32'd0);

        // One-byte frame, START-while-busy ignored, interrupt masking
        buf_model[0] = 32'h000000A5;
        wb_write(8'h40, 32'h000000A5);
        wb_write(8'h00, 32'h1);
        push_frame(1, 1'b0);
        wb_write(8'h0C, 32'h00010001);
        check_eq("start_mtxen", {31'd0, mtxen_o}, 32'd1);
        wb_read(8'h0C, r); check_eq("busy_readback", r, 32'h00010001);
        wb_write(8'h0C, 32'h00010001);
        wait_frames(1, 100);
        wb_read(8'h04, r); check_eq("txb_set", r, 32'h1);
        check_eq("int_masked", {31'd0, int_o}, 32'd0);
        wb_write(8'h08, 32'h1);
        check_eq("int_unmasked", {31'd0, int_o}, 32'd1);
        wb_write(8'h04, 32'h1);
        check_eq("int_cleared", {31'd0, int_o}, 32'd0);
        wb_read(8'h0C, r); check_eq("idle_tx_ctrl", r, 32'h00000001);

        // Five-byte frame across a word boundary; buffer write while busy ignored
        buf_model[0] = 32'h44332211;
        buf_model[1] = 32'h00000055;
        wb_write(8'h40, 32'h44332211);
        wb_write(8'h44, 32'h00000055);
        push_frame(5, 1'b0);
        wb_write(8'h0C, 32'h00010005);
        wb_write(8'h40, 32'h00000000);
        wait_frames(2, 100);
        wb_read(8'h40, r); check_eq("buf_write_busy", r, 32'h44332211);
        wb_read(8'h04, r); check_eq("txb_frame2", r, 32'h1);
        wb_write(8'h04, 32'h3);

        // Rejected starts
        fs0 = frames_seen;
        wb_write(8'h0C, 32'h00010000);
        wb_read(8'h04, r); check_eq("len0_txe", r, 32'h2);
        check_eq("txe_masked_int", {31'd0, int_o}, 32'd0);
        wb_write(8'h04, 32'h3);
        wb_write(8'h0C, 32'h00010041);
        wb_read(8'h04, r); check_eq("len65_txe", r, 32'h2);
        wb_write(8'h04, 32'h3);
        wb_write(8'h00, 32'h0);
        wb_write(8'h0C, 32'h00010001);
        wb_read(8'h04, r); check_eq("txen0_txe", r, 32'h2);
        wb_write(8'h04, 32'h3);
        repeat (25) @(negedge clk);
        check_eq("no_frame", frames_seen, fs0);

        // Unmapped address and MAC storage
        wb_xfer(8'h1C, 1'b1, 32'hFFFFFFFF, r, a, e);
        check_eq("unmapped_err", {31'd0, e}, 32'd1);
        check_eq("unmapped_noack", {31'd0, a}, 32'd0);
        @(negedge clk);
        check_eq("err_one_cycle", {31'd0, wb_bus.wb_err_o}, 32'd0);
        wb_xfer(8'h18, 1'b0, 32'd0, r, a, e);
        check_eq("unmapped_rd_err", {31'd0, e}, 32'd1);
        wb_write(8'h10, 32'hDEADBEEF);
        wb_read(8'h10, r); check_eq("mac_addr0", r, 32'hDEADBEEF);
        wb_write(8'h14, 32'h12345678);
        wb_read(8'h14, r); check_eq("mac_addr1", r, 32'h00005678);

        // Abort by clearing TXEN mid-DATA
        fs0 = frames_seen;
        for (int i = 0; i < 4; i++) begin
            buf_model[i] = 32'h01020304 * (i + 1) ^ 32'hA5A5A5A5;
            wb_write(8'h40 + 8'(4 * i), buf_model[i]);
        end
        wb_write(8'h00, 32'h1);
        push_frame(16, 1'b0);
        abort_full   = 48;
        expect_abort = 1'b1;
        wb_write(8'h0C, 32'h00010010);
        repeat (24) @(negedge clk);
        wb_write(8'h00, 32'h0);
        check_eq("abort_mtxen", {31'd0, mtxen_o}, 32'd0);
        wait_frames(fs0 + 1, 20);
        wb_read(8'h04, r); check_eq("abort_int_src", r, 32'h2);
        wb_read(8'h0C, r); check_eq("abort_idle", r, 32'h00000010);
        wb_write(8'h04, 32'h3);

        // CRCEN writability
        wb_write(8'h00, 32'h3);
        wb_read(8'h00, r);
`ifdef ETHMAC_CRC_EN
        check_eq("moder_crcen", r, 32'h3);
        fs0 = frames_seen;
        buf_model[0] = 32'h00000000;
        wb_write(8'h40, 32'h00000000);
        push_frame(1, 1'b1);
        wb_write(8'h0C, 32'h00010001);
        wait_frames(fs0 + 1, 100);
        wb_read(8'h04, r); check_eq("crc_txb", r, 32'h1);
`else
        check_eq("moder_crcen", r, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
